// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the cache-to-RAM path
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state as reported by the RAM model
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbitration policy of the memory arbiter
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arbmode_t;

    // Memory arbiter control states
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arbstate_t;

    // Width of an index over n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// rtl/arb_picker.sv - combinational winner selection, fixed priority or round robin
module arb_picker
    import cpu_types_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  active_i,
    input  logic [IDX_W-1:0] base_i,
    input  arbmode_t         mode_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             any_valid_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest active one sticks
    always_comb begin
        winner_o    = '0;
        any_valid_o = |active_i;
        sum         = '0;
        idx         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (mode_i == ARB_RR) begin
                sum = {1'b0, base_i} + (IDX_W + 1)'(k);
                if (sum >= (IDX_W + 1)'(NREQ)) begin
                    sum = sum - (IDX_W + 1)'(NREQ);
                end
            end else begin
                sum = (IDX_W + 1)'(k);
            end
            idx = sum[IDX_W-1:0];
            if (active_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - NREQ-way burst arbiter in front of the single-ported RAM
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int       NREQ  = 2,
    parameter int       BURST = 2,
    parameter arbmode_t MODE  = ARB_RR
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_ren,
    input  logic [NREQ-1:0]    req_wen,
    input  word_t [NREQ-1:0]   req_addr,
    input  word_t [NREQ-1:0]   req_store,
    output logic [NREQ-1:0]    req_wait,
    output word_t              req_load,
    output logic [NREQ-1:0]    req_err,
    output logic               ramREN,
    output logic               ramWEN,
    output word_t              ramaddr,
    output word_t              ramstore,
    input  word_t              ramload,
    input  ramstate_t          ramstate
);

    localparam int IDX_W  = idx_width(NREQ);
    localparam int BEAT_W = idx_width(BURST);

    arbstate_t         state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              is_write_q, is_write_d;

    logic [NREQ-1:0]   active;
    logic [IDX_W-1:0]  pick;
    logic              any_valid;
    logic              busy, abort, drive, ack, err, last_beat;

    assign active = req_ren | req_wen;

    arb_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .active_i    (active),
        .base_i      (rr_ptr_q),
        .mode_i      (MODE),
        .winner_o    (pick),
        .any_valid_o (any_valid)
    );

    // Abort detection and RAM-side / requester-side output muxing
    always_comb begin
        busy      = (state_q == ARB_BUSY);
        abort     = busy && (!active[grant_q] || (req_wen[grant_q] != is_write_q));
        drive     = busy && !abort;
        ack       = drive && (ramstate == ACCESS) && !RST;
        err       = drive && (ramstate == ERROR) && !RST;
        last_beat = (beat_q == BEAT_W'(BURST - 1));

        ramREN    = drive && !is_write_q;
        ramWEN    = drive && is_write_q;
        ramaddr   = busy ? (req_addr[grant_q] + (word_t'(beat_q) << 2)) : '0;
        ramstore  = busy ? req_store[grant_q] : '0;

        req_wait  = '1;
        req_err   = '0;
        req_load  = '0;
        if (ack) begin
            req_wait[grant_q] = 1'b0;
            req_load          = ramload;
        end
        if (err) begin
            req_err[grant_q] = 1'b1;
        end
    end

    // Next-state logic: arbitrate in idle, walk beats in busy, release on finish or abort
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_d     = beat_q;
        rr_ptr_d   = rr_ptr_q;
        is_write_d = is_write_q;
        if (state_q == ARB_IDLE) begin
            if (any_valid) begin
                state_d    = ARB_BUSY;
                grant_d    = pick;
                is_write_d = req_wen[pick];
                beat_d     = '0;
            end
        end else if (abort || (ack && last_beat)) begin
            state_d = ARB_IDLE;
            beat_d  = '0;
            if (MODE == ARB_RR) begin
                rr_ptr_d = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
            end
        end else if (ack) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over every transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            beat_q     <= '0;
            rr_ptr_q   <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_q     <= beat_d;
            rr_ptr_q   <= rr_ptr_d;
            is_write_q <= is_write_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic         CLK = 1'b0;
    logic         RST;
    logic [1:0]   ren, wen;
    word_t [1:0]  addr, store;
    word_t        ramload;
    ramstate_t    ramstate;

    logic [1:0]   rr_wait, rr_err, fx_wait, fx_err;
    word_t        rr_load, rr_addr, rr_store, fx_load, fx_addr, fx_store;
    logic         rr_ren, rr_wen, fx_ren, fx_wen;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.NREQ(2), .BURST(2), .MODE(ARB_RR)) u_rr (
        .CLK(CLK), .RST(RST), .req_ren(ren), .req_wen(wen), .req_addr(addr),
        .req_store(store), .req_wait(rr_wait), .req_load(rr_load), .req_err(rr_err),
        .ramREN(rr_ren), .ramWEN(rr_wen), .ramaddr(rr_addr), .ramstore(rr_store),
        .ramload(ramload), .ramstate(ramstate)
    );

    mem_arbiter #(.NREQ(2), .BURST(2), .MODE(ARB_FIXED)) u_fx (
        .CLK(CLK), .RST(RST), .req_ren(ren), .req_wen(wen), .req_addr(addr),
        .req_store(store), .req_wait(fx_wait), .req_load(fx_load), .req_err(fx_err),
        .ramREN(fx_ren), .ramWEN(fx_wen), .ramaddr(fx_addr), .ramstore(fx_store),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_rr_reset_outputs(input string tag);
        chk({tag, "_wait"},  32'(rr_wait),  32'h3);
        chk({tag, "_ren"},   32'(rr_ren),   32'h0);
        chk({tag, "_wen"},   32'(rr_wen),   32'h0);
        chk({tag, "_addr"},  rr_addr,       32'h0);
        chk({tag, "_store"}, rr_store,      32'h0);
        chk({tag, "_load"},  rr_load,       32'h0);
        chk({tag, "_err"},   32'(rr_err),   32'h0);
    endtask

    initial begin
        RST = 1'b1; ren = '0; wen = '0; addr = '0; store = '0;
        ramload = '0; ramstate = FREE;
        tick(); tick(); #1;
        chk_rr_reset_outputs("reset");
        chk("reset_fx_wait", 32'(fx_wait), 32'h3);
        RST = 1'b0;

        // single read by requester 1, ACCESS immediately
        ren = 2'b10; addr[1] = 32'h100; ramstate = ACCESS; #1;
        chk("t1_idle_ren", 32'(rr_ren), 32'h0);
        tick(); ramload = 32'hAAAA0000; #1;
        chk("t1_b0_addr", rr_addr, 32'h100);
        chk("t1_b0_ren",  32'(rr_ren), 32'h1);
        chk("t1_b0_wait", 32'(rr_wait), 32'h1);
        chk("t1_b0_load", rr_load, 32'hAAAA0000);
        tick(); ramload = 32'hAAAA0004; #1;
        chk("t1_b1_addr", rr_addr, 32'h104);
        chk("t1_b1_wait", 32'(rr_wait), 32'h1);
        chk("t1_b1_load", rr_load, 32'hAAAA0004);
        tick(); ren = 2'b00; #1;
        chk("t1_idle_ren2",  32'(rr_ren), 32'h0);
        chk("t1_idle_wait2", 32'(rr_wait), 32'h3);

        // contention: round robin alternates, fixed always picks 0
        ren = 2'b11; addr[0] = 32'h1000; addr[1] = 32'h2000; ramload = '0; #1;
        for (int n = 0; n < 4; n++) begin
            tick(); #1;
            chk("rr_b0_addr", rr_addr, (n % 2 == 1) ? 32'h2000 : 32'h1000);
            chk("rr_b0_wait", 32'(rr_wait), (n % 2 == 1) ? 32'h1 : 32'h2);
            chk("fx_b0_addr", fx_addr, 32'h1000);
            chk("fx_b0_wait", 32'(fx_wait), 32'h2);
            tick(); #1;
            chk("rr_b1_addr", rr_addr, (n % 2 == 1) ? 32'h2004 : 32'h1004);
            tick(); #1;
            chk("rr_gap_ren", 32'(rr_ren), 32'h0);
        end

        // write wins over read; store updated between beats
        ren = 2'b01; wen = 2'b01; addr[0] = 32'h200; store[0] = 32'hDEADBEEF; #1;
        tick(); #1;
        chk("wr_b0_wen",   32'(rr_wen), 32'h1);
        chk("wr_b0_ren",   32'(rr_ren), 32'h0);
        chk("wr_b0_store", rr_store, 32'hDEADBEEF);
        chk("wr_b0_addr",  rr_addr, 32'h200);
        chk("wr_b0_wait",  32'(rr_wait), 32'h2);
        tick(); store[0] = 32'h12345678; #1;
        chk("wr_b1_store", rr_store, 32'h12345678);
        chk("wr_b1_addr",  rr_addr, 32'h204);
        chk("wr_b1_wen",   32'(rr_wen), 32'h1);
        tick(); ren = 2'b00; wen = 2'b00; #1;
        chk("wr_idle_wen", 32'(rr_wen), 32'h0);

        // stall three cycles, one error, then complete
        ren = 2'b10; addr[1] = 32'h300; ramstate = BUSY; ramload = 32'h55AA55AA; #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("st_busy_wait", 32'(rr_wait), 32'h3);
            chk("st_busy_addr", rr_addr, 32'h300);
            chk("st_busy_err",  32'(rr_err), 32'h0);
            chk("st_busy_ren",  32'(rr_ren), 32'h1);
        end
        tick(); ramstate = ERROR; #1;
        chk("st_err_err",  32'(rr_err), 32'h2);
        chk("st_err_wait", 32'(rr_wait), 32'h3);
        chk("st_err_addr", rr_addr, 32'h300);
        tick(); ramstate = ACCESS; #1;
        chk("st_acc_wait", 32'(rr_wait), 32'h1);
        chk("st_acc_load", rr_load, 32'h55AA55AA);
        chk("st_acc_err",  32'(rr_err), 32'h0);
        chk("st_acc_addr", rr_addr, 32'h300);
        tick(); #1;
        chk("st_b1_addr", rr_addr, 32'h304);
        chk("st_b1_wait", 32'(rr_wait), 32'h1);
        tick(); ren = 2'b00; #1;
        chk("st_idle_ren", 32'(rr_ren), 32'h0);

        // abort after beat 0, pending requester granted after the idle cycle
        ren = 2'b11; addr[0] = 32'h1000; addr[1] = 32'h2000; #1;
        tick(); #1;
        chk("ab_b0_addr", rr_addr, 32'h1000);
        chk("ab_b0_wait", 32'(rr_wait), 32'h2);
        tick(); ren = 2'b10; #1;
        chk("ab_drop_ren",  32'(rr_ren), 32'h0);
        chk("ab_drop_wen",  32'(rr_wen), 32'h0);
        chk("ab_drop_wait", 32'(rr_wait), 32'h3);
        tick(); #1;
        chk("ab_idle_ren",  32'(rr_ren), 32'h0);
        chk("ab_idle_wait", 32'(rr_wait), 32'h3);
        tick(); #1;
        chk("ab_next_addr", rr_addr, 32'h2000);
        chk("ab_next_ren",  32'(rr_ren), 32'h1);
        chk("ab_next_wait", 32'(rr_wait), 32'h1);
        tick(); #1;
        chk("ab_next_b1", rr_addr, 32'h2004);

        // reset at beat 1 of a grant-0 burst
        tick(); ren = 2'b11; #1;
        chk("rs_idle_ren", 32'(rr_ren), 32'h0);
        tick(); #1;
        chk("rs_b0_addr", rr_addr, 32'h1000);
        tick(); RST = 1'b1; ramstate = BUSY; #1;
        chk("rs_b1_addr", rr_addr, 32'h1004);
        tick(); RST = 1'b0; ramstate = ACCESS; #1;
        chk_rr_reset_outputs("rs_after");
        tick(); #1;
        chk("rs_regrant_addr", rr_addr, 32'h1000);
        chk("rs_regrant_wait", 32'(rr_wait), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised memory arbiter between NREQ cache-side requesters and the single-ported RAM. It is the generalised successor to the fixed icache/dcache two-port memory controller. It adds a runtime-independent arbitration mode (fixed-priority or round-robin), multi-word bursts for block fills and writebacks, and abort handling. It sits between the caches and the RAM model, and speaks `ramstate_t` on the RAM side.

## Interface
Parameters:
- NREQ, 2, number of requesters; index 0 is the highest fixed priority (icache by convention).
- BURST, 2, words per granted transaction; matches 2**DBLK_W. BURST = 1 is a single-word access.
- MODE, ARB_RR, `arbmode_t`: ARB_FIXED or ARB_RR.

Ports (clock and reset first):
- CLK, in, 1, system clock; all state on the rising edge.
- RST, in, 1, synchronous, active-high reset.
- req_ren, in, NREQ, per-requester read request.
- req_wen, in, NREQ, per-requester write request.
- req_addr, in, NREQ x word_t, per-requester burst base address (word aligned).
- req_store, in, NREQ x word_t, per-requester write data for the current beat.
- req_wait, out, NREQ, high = beat not complete; low for exactly one cycle per completed beat.
- req_load, out, word_t, read data; valid for the requester whose req_wait is low.
- req_err, out, NREQ, one-cycle pulse when that requester's beat sees ERROR.
- ramREN, out, 1, RAM read enable.
- ramWEN, out, 1, RAM write enable.
- ramaddr, out, word_t, RAM address.
- ramstore, out, word_t, RAM write data.
- ramload, in, word_t, RAM read data.
- ramstate, in, `ramstate_t`, FREE, BUSY, ACCESS or ERROR.

## Operation
- Request i is active when req_ren[i] | req_wen[i]. If both are set, the write wins.
- Requesters hold ren, wen and addr stable for the whole burst. req_store may change only after a beat completes.
- States are ARB_IDLE and ARB_BUSY, with registers grant, beat (clog2(BURST) bits), rr_ptr and is_write.
- ARB_IDLE:
  - If no request is active, stay in ARB_IDLE.
  - Otherwise pick a winner, latch grant and is_write, clear beat, and go to ARB_BUSY.
- Winner selection:
  - ARB_FIXED: lowest active index wins.
  - ARB_RR: first active index at or after rr_ptr, wrapping modulo NREQ.
- ARB_BUSY:
  - ramREN = !is_write and ramWEN = is_write.
  - ramaddr = req_addr[grant] + 4*beat.
  - ramstore = req_store[grant].
- ramstate handling in ARB_BUSY:
  - ACCESS: req_wait[grant] goes low this cycle and req_load = ramload. If beat == BURST-1, return to ARB_IDLE; otherwise increment beat.
  - BUSY or FREE: hold.
  - ERROR: pulse req_err[grant], keep req_wait high and retry the same beat.
- On return to ARB_IDLE (burst complete or abort), ARB_RR sets rr_ptr = (grant+1) mod NREQ. ARB_FIXED ignores rr_ptr.
- Abort: if the granted request drops, or its ren/wen polarity changes, before the last beat:
  - ramREN and ramWEN are forced to 0 that same cycle.
  - The state goes to ARB_IDLE next cycle. beat is discarded and no completion is signalled.
- Non-granted requesters always see req_wait = 1 and req_err = 0.
- Address arithmetic is modulo 2**32; a burst may wrap past 0xFFFFFFFC.
- Reset values: state ARB_IDLE, grant = 0, beat = 0, rr_ptr = 0; ramREN = ramWEN = 0; ramaddr = ramstore = 0; req_wait = all 1s; req_load = 0; req_err = 0.

## Timing
- Grant is registered: a request first seen at edge t drives RAM enables in cycle t+1.
- ramstate and ramload are used combinationally. With ACCESS in cycle t+1, the first beat completes in t+1.
- Minimum burst latency is BURST+1 cycles from request to final req_wait low. Requesters are back-to-back with one idle arbitration cycle between bursts.
- RAM outputs are combinational from grant, beat and the requester inputs, with no extra cycle.
- RST has priority over every transition. Reset mid-burst drops the RAM enables in the next cycle, with no completion or error pulse.

## Structure
- The following go in cpu_types_pkg next to `ramstate_t`:
  - typedef enum `arbmode_t` {ARB_FIXED, ARB_RR}.
  - typedef enum `arbstate_t` {ARB_IDLE, ARB_BUSY}.
- One sub-module, arb_picker: combinational, parametrised on NREQ. Inputs are the active vector, base index and mode. Outputs are winner index and any_valid. It is reused later by the bus snooper.
- The top level holds the FSM, beat counter, rr_ptr and output muxing.

## Test plan
- Single read, NREQ = 2, BURST = 2, MODE = ARB_RR: req 1 reads 0x100 with ACCESS immediate → ramaddr 0x100 then 0x104. req_wait[1] is low in cycles 2 and 3, with req_load = 0xAAAA0000 then 0xAAAA0004. Back in ARB_IDLE in cycle 4 with rr_ptr = 0.
- Contention, ARB_RR: req 0 and req 1 held active continuously → grants alternate 0, 1, 0, 1. ARB_FIXED with the same stimulus → always grant 0.
- Write priority: req 0 asserts ren and wen at 0x200, store 0xDEADBEEF → ramWEN = 1, ramREN = 0, ramstore = 0xDEADBEEF, and the second beat sends the updated store to 0x204.
- RAM stall and error: ramstate BUSY for 3 cycles, ERROR for 1 cycle, then ACCESS → req_wait stays high for 4 cycles, req_err pulses once, the beat completes on ACCESS, and ramaddr is unchanged throughout.
- Abort: the granted requester drops its request after beat 0 → RAM enables are 0 the same cycle, ARB_IDLE next cycle, a pending requester is granted the following cycle, and beat restarts at 0.
- Reset mid-burst: RST asserted while in ARB_BUSY at beat 1 → next cycle every output is at its reset value, and rr_ptr = 0 regardless of the previous grant.
